// File: rtl/apb_uart_pkg.sv
// Shared UART constants used as parameter defaults by the FIFO blocks.
package apb_uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int UART_FIFO_DEPTH = 16;

endpackage

// File: rtl/apb_uart_fifo_mem.sv
// Flop-based FIFO storage: synchronous write, asynchronous read, no reset.
module apb_uart_fifo_mem
   import apb_uart_pkg::*;
#(
   parameter int WIDTH  = UART_DATA_W,
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [AWIDTH-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_uart_fifo_th.sv
// Show-ahead FIFO with registered full/empty/almost flags, runtime thresholds
// and sticky overflow/underflow error flags.
module apb_uart_fifo_th
   import apb_uart_pkg::*;
#(
   parameter int WIDTH  = UART_DATA_W,
   parameter int DEPTH  = UART_FIFO_DEPTH,
   parameter int AWIDTH = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              flush,
   input  logic              push,
   input  logic [WIDTH-1:0]  din,
   input  logic              pop,
   output logic [WIDTH-1:0]  dout,
   input  logic [AWIDTH:0]   afull_th,
   input  logic [AWIDTH:0]   aempty_th,
   input  logic              clr_err,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AWIDTH:0]   entry,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [AWIDTH:0] DEPTH_CNT = (AWIDTH+1)'(DEPTH);

   logic [AWIDTH:0] wr_ptr, rd_ptr;
   logic [AWIDTH:0] wr_ptr_nxt, rd_ptr_nxt, entry_nxt;
   logic            wr_acc, rd_acc;
   logic            ovf_set, udf_set;

   // A push into a full FIFO is still taken when a read frees a slot in the same cycle.
   assign rd_acc  = pop  & ~flush & ~empty;
   assign wr_acc  = push & ~flush & (~full | rd_acc);
   assign ovf_set = push & ~flush & ~wr_acc;
   assign udf_set = pop  & ~flush & empty;

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (flush) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end else begin
         if (wr_acc) wr_ptr_nxt = wr_ptr + 1'b1;
         if (rd_acc) rd_ptr_nxt = rd_ptr + 1'b1;
      end
      entry_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   assign entry = wr_ptr - rd_ptr;

   // Flags are derived from next-state occupancy so they never lag entry.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         full         <= (entry_nxt == DEPTH_CNT);
         empty        <= (entry_nxt == '0);
         almost_full  <= (entry_nxt >= afull_th);
         almost_empty <= (entry_nxt <= aempty_th);
      end
   end

   // A new error in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (udf_set)      underflow <= 1'b1;
         else if (clr_err) underflow <= 1'b0;
      end
   end

   apb_uart_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr[AWIDTH-1:0]),
      .wdata (din),
      .raddr (rd_ptr[AWIDTH-1:0]),
      .rdata (dout)
   );

endmodule

// File: tb/tb_apb_uart_fifo_th.sv
// Directed bench for apb_uart_fifo_th with DEPTH=4, WIDTH=8.
module tb_apb_uart_fifo_th;

   localparam int WIDTH  = 8;
   localparam int DEPTH  = 4;
   localparam int AWIDTH = 2;

   logic              clk = 1'b0;
   logic              rst_b = 1'b0;
   logic              flush = 1'b0;
   logic              push = 1'b0;
   logic [WIDTH-1:0]  din = '0;
   logic              pop = 1'b0;
   logic [WIDTH-1:0]  dout;
   logic [AWIDTH:0]   afull_th = 3'd3;
   logic [AWIDTH:0]   aempty_th = 3'd1;
   logic              clr_err = 1'b0;
   logic              full, empty, almost_full, almost_empty;
   logic [AWIDTH:0]   entry;
   logic              overflow, underflow;
   logic [5:0]        flg;

   int n_cmp = 0;
   int n_bad = 0;

   assign flg = {full, empty, almost_full, almost_empty, overflow, underflow};

   always #5 clk = ~clk;

   apb_uart_fifo_th #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .flush        (flush),
      .push         (push),
      .din          (din),
      .pop          (pop),
      .dout         (dout),
      .afull_th     (afull_th),
      .aempty_th    (aempty_th),
      .clr_err      (clr_err),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .entry        (entry),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   // Advance one edge and settle; all inputs return to idle afterwards.
   task automatic step();
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
   endtask

   task automatic test_reset();
      rst_b = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (entry !== 3'd0) begin n_bad++; $display("FAIL reset_entry got=%0d want=0", entry); end
      n_cmp++;
      if (flg !== 6'b010100) begin n_bad++; $display("FAIL reset_flags got=%b want=010100", flg); end
      rst_b = 1'b1;
      step();
   endtask

   task automatic test_fill();
      logic [7:0] dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [5:0] exp [4] = '{6'b000100, 6'b000000, 6'b001000, 6'b101000};
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; din = dat[i];
         step();
         n_cmp++;
         if (entry !== 3'(i + 1)) begin n_bad++; $display("FAIL fill_entry[%0d] got=%0d want=%0d", i, entry, i + 1); end
         n_cmp++;
         if (flg !== exp[i]) begin n_bad++; $display("FAIL fill_flags[%0d] got=%b want=%b", i, flg, exp[i]); end
         n_cmp++;
         if (dout !== 8'h11) begin n_bad++; $display("FAIL fill_dout[%0d] got=%h want=11", i, dout); end
      end
   endtask

   task automatic test_overflow();
      push = 1'b1; din = 8'h55;
      step();
      n_cmp++;
      if (entry !== 3'd4) begin n_bad++; $display("FAIL ovf_entry got=%0d want=4", entry); end
      n_cmp++;
      if (flg !== 6'b101010) begin n_bad++; $display("FAIL ovf_flags got=%b want=101010", flg); end
      n_cmp++;
      if (dout !== 8'h11) begin n_bad++; $display("FAIL ovf_dout got=%h want=11", dout); end
      step();
      n_cmp++;
      if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
      clr_err = 1'b1;
      step();
      n_cmp++;
      if (flg !== 6'b101000) begin n_bad++; $display("FAIL ovf_clr got=%b want=101000", flg); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_d [4] = '{8'h22, 8'h33, 8'h44, 8'h66};
      logic [5:0] exp_f [5] = '{6'b001000, 6'b000000, 6'b000100, 6'b010100, 6'b010101};
      push = 1'b1; din = 8'h66; pop = 1'b1;
      step();
      n_cmp++;
      if (dout !== 8'h22) begin n_bad++; $display("FAIL fpp_dout got=%h want=22", dout); end
      n_cmp++;
      if (entry !== 3'd4) begin n_bad++; $display("FAIL fpp_entry got=%0d want=4", entry); end
      n_cmp++;
      if (flg !== 6'b101000) begin n_bad++; $display("FAIL fpp_flags got=%b want=101000", flg); end
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            n_cmp++;
            if (dout !== exp_d[i]) begin n_bad++; $display("FAIL fpp_order[%0d] got=%h want=%h", i, dout, exp_d[i]); end
         end
         pop = 1'b1;
         step();
         n_cmp++;
         if (flg !== exp_f[i]) begin n_bad++; $display("FAIL fpp_pop_flags[%0d] got=%b want=%b", i, flg, exp_f[i]); end
      end
      n_cmp++;
      if (entry !== 3'd0) begin n_bad++; $display("FAIL fpp_final_entry got=%0d want=0", entry); end
   endtask

   task automatic test_empty_push_pop();
      clr_err = 1'b1;
      step();
      push = 1'b1; din = 8'h77; pop = 1'b1;
      step();
      n_cmp++;
      if (entry !== 3'd1) begin n_bad++; $display("FAIL epp_entry got=%0d want=1", entry); end
      n_cmp++;
      if (flg !== 6'b000101) begin n_bad++; $display("FAIL epp_flags got=%b want=000101", flg); end
      n_cmp++;
      if (dout !== 8'h77) begin n_bad++; $display("FAIL epp_dout got=%h want=77", dout); end
      pop = 1'b1;
      step();
      clr_err = 1'b1;
      step();
      n_cmp++;
      if (flg !== 6'b010100) begin n_bad++; $display("FAIL epp_drain got=%b want=010100", flg); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         push = 1'b1; din = 8'hB0 + 8'(i);
         step();
      end
      for (int k = 0; k < 10; k++) begin
         n_cmp++;
         if (dout !== 8'hB0 + 8'(k)) begin n_bad++; $display("FAIL wrap_dout[%0d] got=%h want=%h", k, dout, 8'hB0 + 8'(k)); end
         push = 1'b1; din = 8'hB3 + 8'(k); pop = 1'b1;
         step();
         n_cmp++;
         if (entry !== 3'd3 || flg !== 6'b001000) begin
            n_bad++; $display("FAIL wrap_state[%0d] got=%0d/%b want=3/001000", k, entry, flg);
         end
      end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (dout !== 8'hBA + 8'(i)) begin n_bad++; $display("FAIL wrap_drain[%0d] got=%h want=%h", i, dout, 8'hBA + 8'(i)); end
         pop = 1'b1;
         step();
      end
      n_cmp++;
      if (flg !== 6'b010100) begin n_bad++; $display("FAIL wrap_empty got=%b want=010100", flg); end
   endtask

   task automatic test_thresholds();
      afull_th = 3'd0;
      #1;
      n_cmp++;
      if (almost_full !== 1'b0) begin n_bad++; $display("FAIL th_af_hold got=%b want=0", almost_full); end
      step();
      n_cmp++;
      if (flg !== 6'b011100) begin n_bad++; $display("FAIL th_af_set got=%b want=011100", flg); end
      afull_th = 3'd3;
      push = 1'b1; din = 8'hC1;
      step();
      n_cmp++;
      if (flg !== 6'b000100) begin n_bad++; $display("FAIL th_one got=%b want=000100", flg); end
      aempty_th = 3'd0;
      step();
      n_cmp++;
      if (flg !== 6'b000000) begin n_bad++; $display("FAIL th_ae_clr got=%b want=000000", flg); end
      aempty_th = 3'd1;
      step();
      n_cmp++;
      if (flg !== 6'b000100) begin n_bad++; $display("FAIL th_ae_set got=%b want=000100", flg); end
      pop = 1'b1;
      step();
   endtask

   task automatic test_flush();
      pop = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
         push = 1'b1; din = 8'hD0 + 8'(i);
         step();
      end
      pop = 1'b1;
      step();
      n_cmp++;
      if (entry !== 3'd3 || flg !== 6'b001011) begin
         n_bad++; $display("FAIL flush_pre got=%0d/%b want=3/001011", entry, flg);
      end
      flush = 1'b1; push = 1'b1; din = 8'hE0;
      step();
      n_cmp++;
      if (entry !== 3'd0) begin n_bad++; $display("FAIL flush_entry got=%0d want=0", entry); end
      n_cmp++;
      if (flg !== 6'b010111) begin n_bad++; $display("FAIL flush_flags got=%b want=010111", flg); end
      clr_err = 1'b1;
      step();
      n_cmp++;
      if (flg !== 6'b010100) begin n_bad++; $display("FAIL flush_clr got=%b want=010100", flg); end
   endtask

   task automatic test_reset_mid();
      push = 1'b1; din = 8'hF0;
      step();
      push = 1'b1; din = 8'hF1;
      step();
      n_cmp++;
      if (entry !== 3'd2) begin n_bad++; $display("FAIL rmid_pre got=%0d want=2", entry); end
      #2 rst_b = 1'b0;
      #1;
      n_cmp++;
      if (entry !== 3'd0 || flg !== 6'b010100) begin
         n_bad++; $display("FAIL rmid_async got=%0d/%b want=0/010100", entry, flg);
      end
      @(posedge clk); #1;
      rst_b = 1'b1;
      push = 1'b1; din = 8'hA5;
      step();
      n_cmp++;
      if (dout !== 8'hA5) begin n_bad++; $display("FAIL rmid_dout got=%h want=a5", dout); end
      n_cmp++;
      if (entry !== 3'd1 || flg !== 6'b000100) begin
         n_bad++; $display("FAIL rmid_post got=%0d/%b want=1/000100", entry, flg);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_wrap();
      test_thresholds();
      test_flush();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
